// File: rtl/led_status_pkg.sv
// Shared definitions for the status-LED driver: mode codes, channel FSM
// encoding and a small helper for sizing the per-channel tick counter.
package led_status_pkg;

  localparam int MODE_W = 3;
  localparam int CODE_W = 3;

  localparam logic [MODE_W-1:0] LED_OFF  = 3'd0;
  localparam logic [MODE_W-1:0] LED_ON   = 3'd1;
  localparam logic [MODE_W-1:0] LED_SLOW = 3'd2;
  localparam logic [MODE_W-1:0] LED_FAST = 3'd3;
  localparam logic [MODE_W-1:0] LED_ACT  = 3'd4;
  localparam logic [MODE_W-1:0] LED_CODE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFF_PH = 2'd1,
    ST_ON_PH  = 2'd2,
    ST_GAP    = 2'd3
  } chan_state_e;

  // Largest of three phase lengths; sizes the shared per-channel counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/led_status_channel.sv
// One LED channel: mode-change detect, ACT/CODE sequencing FSM with its own
// tick counter, and the active-high "lit" decision for every mode.
//
// Handshake note: there is no valid/ready handshake here; event_i is a level
// sampled every cycle and tick_i is a one-cycle strobe qualifying counting.
module led_status_channel
  import led_status_pkg::*;
#(
  parameter int ACT_HALF   = 40,
  parameter int CODE_PULSE = 200,
  parameter int CODE_GAP   = 1000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              slow_ph_i,
  input  logic              fast_ph_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              event_i,
  output logic              lit_o
);

  localparam int CNT_W = $clog2(max3(ACT_HALF, CODE_PULSE, CODE_GAP) + 1);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(ACT_HALF - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(CODE_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CODE_GAP - 1);

  chan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CODE_W-1:0] rem_q, rem_d;
  logic              pend_q, pend_d;

  // State register: everything returns to idle/zero on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= LED_OFF;
      rem_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state: a mode change restarts the sequence; otherwise ACT or CODE
  // sequencing advances its counter on each tick until the phase ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    if (mode_i != mode_q) begin
      mode_d  = mode_i;
      state_d = (mode_i == LED_CODE) ? ST_GAP : ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (mode_q == LED_ACT) begin
      case (state_q)
        ST_IDLE: begin
          if (event_i) begin
            state_d = ST_OFF_PH;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end
        end
        ST_OFF_PH: begin
          pend_d = pend_q | event_i;
          if (tick_i) begin
            if (cnt_q == ACT_LAST) begin
              cnt_d   = '0;
              state_d = ST_ON_PH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ON_PH: begin
          pend_d = pend_q | event_i;
          if (tick_i) begin
            if (cnt_q == ACT_LAST) begin
              cnt_d   = '0;
              pend_d  = 1'b0;
              // Traffic seen during the flash earns another flash.
              state_d = (pend_q | event_i) ? ST_OFF_PH : ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (mode_q == LED_CODE) begin
      case (state_q)
        ST_GAP: begin
          if (tick_i) begin
            if (cnt_q == GAP_LAST) begin
              cnt_d   = '0;
              rem_d   = code_i;
              state_d = (code_i == '0) ? ST_GAP : ST_ON_PH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ON_PH: begin
          if (tick_i) begin
            if (cnt_q == PULSE_LAST) begin
              cnt_d   = '0;
              state_d = ST_OFF_PH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OFF_PH: begin
          if (tick_i) begin
            if (cnt_q == PULSE_LAST) begin
              cnt_d   = '0;
              rem_d   = rem_q - CODE_W'(1);
              state_d = (rem_q == CODE_W'(1)) ? ST_GAP : ST_ON_PH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_GAP;
      endcase
    end
  end

  // Output decode: lit level from the registered mode and FSM state.
  always_comb begin
    lit_o = 1'b0;
    case (mode_q)
      LED_OFF:  lit_o = 1'b0;
      LED_ON:   lit_o = 1'b1;
      LED_SLOW: lit_o = slow_ph_i;
      LED_FAST: lit_o = fast_ph_i;
      LED_ACT:  lit_o = (state_q == ST_IDLE) || (state_q == ST_ON_PH);
      LED_CODE: lit_o = (state_q == ST_ON_PH);
      default:  lit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver: prescaled timebase, shared slow/fast blink
// phases so blinking channels stay in step, per-channel sequencers, and a
// registered output with optional active-low polarity.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int NUM_LEDS    = 4,
  parameter int SLOW_HALF   = 500,
  parameter int FAST_HALF   = 62,
  parameter int ACT_HALF    = 40,
  parameter int CODE_PULSE  = 200,
  parameter int CODE_GAP    = 1000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [MODE_W*NUM_LEDS-1:0] mode_i,
  input  logic [CODE_W*NUM_LEDS-1:0] code_i,
  input  logic [NUM_LEDS-1:0]        event_i,
  output logic [NUM_LEDS-1:0]        led_o,
  output logic                       tick_o
);

  localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
  localparam int PS_W     = $clog2(PRESCALE);
  localparam int SLOW_W   = $clog2(SLOW_HALF + 1);
  localparam int FAST_W   = $clog2(FAST_HALF + 1);
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF - 1);
  localparam logic              UNLIT     = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic [SLOW_W-1:0]   slow_cnt_q, slow_cnt_d;
  logic [FAST_W-1:0]   fast_cnt_q, fast_cnt_d;
  logic                slow_ph_q, slow_ph_d;
  logic                fast_ph_q, fast_ph_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] lit;
  logic                tick;

  assign tick   = (pre_cnt_q == PS_LAST);
  assign tick_o = tick;
  assign led_o  = led_q;

  // Timebase and shared blink-phase registers plus the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt_q  <= '0;
      slow_cnt_q <= '0;
      fast_cnt_q <= '0;
      slow_ph_q  <= 1'b0;
      fast_ph_q  <= 1'b0;
      led_q      <= {NUM_LEDS{UNLIT}};
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      slow_cnt_q <= slow_cnt_d;
      fast_cnt_q <= fast_cnt_d;
      slow_ph_q  <= slow_ph_d;
      fast_ph_q  <= fast_ph_d;
      led_q      <= led_d;
    end
  end

  // Prescaler wraps after PRESCALE cycles; the last count is the tick.
  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + PS_W'(1);
  end

  // Shared half-period counters: phases flip once per SLOW_HALF/FAST_HALF ticks.
  always_comb begin
    slow_cnt_d = slow_cnt_q;
    slow_ph_d  = slow_ph_q;
    fast_cnt_d = fast_cnt_q;
    fast_ph_d  = fast_ph_q;
    if (tick) begin
      if (slow_cnt_q == SLOW_LAST) begin
        slow_cnt_d = '0;
        slow_ph_d  = ~slow_ph_q;
      end else begin
        slow_cnt_d = slow_cnt_q + SLOW_W'(1);
      end
      if (fast_cnt_q == FAST_LAST) begin
        fast_cnt_d = '0;
        fast_ph_d  = ~fast_ph_q;
      end else begin
        fast_cnt_d = fast_cnt_q + FAST_W'(1);
      end
    end
  end

  // Output polarity applied before the led register so led_o is glitch-free.
  always_comb begin
    led_d = lit ^ {NUM_LEDS{UNLIT}};
  end

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_chan
    led_status_channel #(
      .ACT_HALF   (ACT_HALF),
      .CODE_PULSE (CODE_PULSE),
      .CODE_GAP   (CODE_GAP)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (tick),
      .slow_ph_i (slow_ph_q),
      .fast_ph_i (fast_ph_q),
      .mode_i    (mode_i[MODE_W*k +: MODE_W]),
      .code_i    (code_i[CODE_W*k +: CODE_W]),
      .event_i   (event_i[k]),
      .lit_o     (lit[k])
    );
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with a small timebase (PRESCALE=10).
// An active-high and an active-low instance share all inputs.
module tb_led_status_ctrl;

  localparam int N = 4;

  localparam logic [11:0] M_OFF     = 12'd0;
  localparam logic [11:0] M_STAT    = {3'd3, 3'd2, 3'd0, 3'd1};
  localparam logic [11:0] M_ACT     = {3'd0, 3'd0, 3'd0, 3'd4};
  localparam logic [11:0] M_CODE    = {3'd5, 3'd5, 3'd0, 3'd4};
  localparam logic [11:0] M_CODE_ON = {3'd5, 3'd1, 3'd0, 3'd4};
  localparam logic [11:0] M_RST     = {3'd0, 3'd0, 3'd1, 3'd4};
  localparam logic [11:0] C_0       = 12'd0;
  localparam logic [11:0] C_3       = {3'd0, 3'd3, 3'd0, 3'd0};
  localparam logic [11:0] C_1       = {3'd0, 3'd1, 3'd0, 3'd0};

  typedef struct {
    int          at_edge;
    logic [11:0] mode;
    logic [11:0] code;
    logic [3:0]  ev;
    logic [3:0]  exp_led;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [11:0]  mode, code;
  logic [N-1:0] ev;
  logic [N-1:0] led, led_al;
  logic         tick, tick_al;

  int   edge_n = 0;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];

  // Edges since reset release; expected values are written against this.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  led_status_ctrl #(
    .CLK_FREQ_HZ(1000), .TICK_HZ(100), .NUM_LEDS(N), .SLOW_HALF(4), .FAST_HALF(2),
    .ACT_HALF(3), .CODE_PULSE(2), .CODE_GAP(5), .ACTIVE_LOW(0)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .code_i(code),
    .event_i(ev), .led_o(led), .tick_o(tick)
  );

  led_status_ctrl #(
    .CLK_FREQ_HZ(1000), .TICK_HZ(100), .NUM_LEDS(N), .SLOW_HALF(4), .FAST_HALF(2),
    .ACT_HALF(3), .CODE_PULSE(2), .CODE_GAP(5), .ACTIVE_LOW(1)
  ) u_dut_al (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .code_i(code),
    .event_i(ev), .led_o(led_al), .tick_o(tick_al)
  );

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_led(input string tag, input logic [3:0] exp);
    check($sformatf("led@%s", tag), {28'd0, led}, {28'd0, exp});
    check($sformatf("led_al@%s", tag), {28'd0, led_al}, {28'd0, ~exp});
  endtask

  // driver
  task automatic step_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic add_vec(input int e, input logic [11:0] m, input logic [11:0] c,
                         input logic [3:0] v, input logic [3:0] x);
    vec_t t;
    t.at_edge = e; t.mode = m; t.code = c; t.ev = v; t.exp_led = x;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // static + shared blink phases
    add_vec( 41, M_STAT, C_0, 4'b0000, 4'b0000);
    add_vec( 42, M_STAT, C_0, 4'b0000, 4'b0101);
    add_vec( 60, M_STAT, C_0, 4'b0000, 4'b0101);
    add_vec( 61, M_STAT, C_0, 4'b0000, 4'b1101);
    add_vec( 80, M_STAT, C_0, 4'b0000, 4'b1101);
    add_vec( 81, M_STAT, C_0, 4'b0000, 4'b0001);
    add_vec(101, M_STAT, C_0, 4'b0000, 4'b1001);
    add_vec(121, M_STAT, C_0, 4'b0000, 4'b0101);
    // ACT: single one-cycle event
    add_vec(123, M_ACT, C_0, 4'b0000, 4'b0001);
    add_vec(124, M_ACT, C_0, 4'b0000, 4'b0001);
    add_vec(125, M_ACT, C_0, 4'b0001, 4'b0001);
    add_vec(126, M_ACT, C_0, 4'b0000, 4'b0000);
    add_vec(150, M_ACT, C_0, 4'b0000, 4'b0000);
    add_vec(151, M_ACT, C_0, 4'b0000, 4'b0001);
    add_vec(181, M_ACT, C_0, 4'b0000, 4'b0001);
    add_vec(200, M_ACT, C_0, 4'b0000, 4'b0001);
    // ACT: event held for 100 cycles
    add_vec(201, M_ACT, C_0, 4'b0001, 4'b0001);
    add_vec(202, M_ACT, C_0, 4'b0001, 4'b0000);
    add_vec(230, M_ACT, C_0, 4'b0001, 4'b0000);
    add_vec(231, M_ACT, C_0, 4'b0001, 4'b0001);
    add_vec(260, M_ACT, C_0, 4'b0001, 4'b0001);
    add_vec(261, M_ACT, C_0, 4'b0001, 4'b0000);
    add_vec(291, M_ACT, C_0, 4'b0001, 4'b0001);
    add_vec(300, M_ACT, C_0, 4'b0001, 4'b0001);
    add_vec(301, M_ACT, C_0, 4'b0000, 4'b0001);
    add_vec(320, M_ACT, C_0, 4'b0000, 4'b0001);
    add_vec(321, M_ACT, C_0, 4'b0000, 4'b0000);
    add_vec(350, M_ACT, C_0, 4'b0000, 4'b0000);
    add_vec(351, M_ACT, C_0, 4'b0000, 4'b0001);
    add_vec(400, M_ACT, C_0, 4'b0000, 4'b0001);
    // CODE: ch2 code 3, ch3 code 0; event on OFF ch1 is ignored
    add_vec(401, M_CODE, C_3, 4'b0010, 4'b0001);
    add_vec(450, M_CODE, C_3, 4'b0000, 4'b0001);
    add_vec(451, M_CODE, C_3, 4'b0000, 4'b0101);
    add_vec(470, M_CODE, C_3, 4'b0000, 4'b0101);
    add_vec(471, M_CODE, C_3, 4'b0000, 4'b0001);
    add_vec(491, M_CODE, C_3, 4'b0000, 4'b0101);
    // code changed mid-sequence: current burst stays at 3, next burst is 1
    add_vec(531, M_CODE, C_1, 4'b0000, 4'b0101);
    add_vec(551, M_CODE, C_1, 4'b0000, 4'b0001);
    add_vec(570, M_CODE, C_1, 4'b0000, 4'b0001);
    add_vec(620, M_CODE, C_1, 4'b0000, 4'b0001);
    add_vec(621, M_CODE, C_1, 4'b0000, 4'b0101);
    add_vec(640, M_CODE, C_1, 4'b0000, 4'b0101);
    add_vec(641, M_CODE, C_1, 4'b0000, 4'b0001);
    add_vec(661, M_CODE, C_1, 4'b0000, 4'b0001);
    add_vec(711, M_CODE, C_1, 4'b0000, 4'b0101);
    add_vec(735, M_CODE, C_1, 4'b0000, 4'b0001);
    // mode change mid-pulse to ON, then back to CODE restarting at GAP
    add_vec(736, M_CODE_ON, C_1, 4'b0000, 4'b0001);
    add_vec(737, M_CODE_ON, C_1, 4'b0000, 4'b0101);
    add_vec(745, M_CODE_ON, C_1, 4'b0000, 4'b0101);
    add_vec(746, M_CODE,    C_1, 4'b0000, 4'b0101);
    add_vec(747, M_CODE,    C_1, 4'b0000, 4'b0001);
    add_vec(790, M_CODE,    C_1, 4'b0000, 4'b0001);
    add_vec(791, M_CODE,    C_1, 4'b0000, 4'b0101);

    // reset phase
    rst_n = 1'b0;
    mode  = M_OFF;
    code  = C_0;
    ev    = '0;
    repeat (5) @(negedge clk);
    check_led("in_reset", 4'b0000);
    check("tick_in_reset", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;
    check_led("released", 4'b0000);

    // prescaler: tick on every 10th edge, one cycle wide
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("tick@%0d", k), {31'd0, tick}, {31'd0, (k % 10) == 9});
    end
    check("tick_al@40", {31'd0, tick_al}, 32'd0);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode;
      code = vecs[i].code;
      ev   = vecs[i].ev;
      step_to(vecs[i].at_edge);
      check_led($sformatf("%0d", vecs[i].at_edge), vecs[i].exp_led);
    end

    // async reset in the middle of an ACT flash
    mode = M_RST;
    code = C_0;
    ev   = '0;
    step_to(793);
    check_led("793", 4'b0011);
    step_to(800);
    ev = 4'b0001;
    step_to(801);
    ev = 4'b0000;
    step_to(805);
    check_led("805_flash", 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check_led("async_rst", 4'b0000);
    check("tick_async_rst", {31'd0, tick}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_led("rel_e1", 4'b0000);
    @(negedge clk);
    check_led("rel_e2", 4'b0011);
    step_to(9);
    check("tick_after_rerelease", {31'd0, tick}, 32'd1);
    step_to(10);
    check("tick_width_after_rerelease", {31'd0, tick}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
